lii_stream_wrapper: RTL

Parametrised successor of the single-stream flow-calc wrapper. It sits between one LII phy input/output channel pair and an HLS kernel with NIN logical input streams and NOUT logical output streams. Inbound beats are demultiplexed by the LII dst field into per-stream FIFOs. Outbound kernel beats are buffered per stream, merged by a round-robin arbiter and tagged with src/dst. Kernel clock-enable derives from output buffer occupancy, not raw downstream tready.

---
 rtl/lii_pkg.sv | 13 +
 rtl/lii_sync_fifo.sv | 56 +++++
 rtl/lii_stream_wrapper.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lii_pkg.sv
// Shared LII identifier types and the stream-index helper used by the wrapper.
package lii_pkg;

  localparam int LII_ID_W = 8;

  typedef logic [LII_ID_W-1:0] lii_id_t;

  // Modulo-256 offset of an LII ID from a base; callers range-check against the stream count
  function automatic lii_id_t stream_index(lii_id_t id, lii_id_t base);
    return id - base;
  endfunction

endpackage

// File: rtl/lii_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and occupancy count.
module lii_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/lii_stream_wrapper.sv
// LII channel pair to multi-stream kernel adapter: dst-based inbound demux into
// per-stream FIFOs, round-robin merge of kernel output FIFOs into one tagged outbound register.
module lii_stream_wrapper
  import lii_pkg::*;
#(
  parameter int      NIN      = 2,
  parameter int      NOUT     = 2,
  parameter int      PW       = 256,
  parameter int      IW       = 192,
  parameter int      OW       = 64,
  parameter int      DEPTH    = 4,
  parameter lii_id_t IN_BASE  = 8'h00,
  parameter lii_id_t OUT_BASE = 8'h00
) (
  input  logic                 aclk,
  input  logic                 arstn,
  input  logic [PW-1:0]        lii_in_p0_tdata,
  input  logic                 lii_in_p0_tvalid,
  output logic                 lii_in_p0_tready,
  input  logic [7:0]           lii_in_p0_src,
  input  logic [7:0]           lii_in_p0_dst,
  output logic [PW-1:0]        lii_out_p0_tdata,
  output logic                 lii_out_p0_tvalid,
  input  logic                 lii_out_p0_tready,
  output logic [7:0]           lii_out_p0_src,
  output logic [7:0]           lii_out_p0_dst,
  input  logic [NOUT*8-1:0]    out_dst,
  output logic [NIN*IW-1:0]    k_in_tdata,
  output logic [NIN-1:0]       k_in_tvalid,
  input  logic [NIN-1:0]       k_in_tready,
  input  logic [NOUT*OW-1:0]   k_out_tdata,
  input  logic [NOUT-1:0]      k_out_tvalid,
  output logic [NOUT-1:0]      k_out_tready,
  output logic                 ce,
  output logic [15:0]          drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (NOUT > 1) ? $clog2(NOUT) : 1;

  lii_id_t         in_idx;
  logic            in_idx_ok, in_sel_full, in_hs;
  logic [NIN-1:0]  in_full, in_empty, in_push, in_pop;
  logic [IW-1:0]   in_dout [NIN];
  logic [CW-1:0]   unused_in_count [NIN];

  logic [NOUT-1:0] out_full, out_empty, out_push, out_pop;
  logic [OW-1:0]   out_dout [NOUT];
  logic [CW-1:0]   unused_out_count [NOUT];

  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic            ovalid_q, ovalid_d;
  logic [OW-1:0]   odata_q, odata_d;
  lii_id_t         osrc_q, osrc_d;
  lii_id_t         odst_q, odst_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;

  logic            grant_found, load;
  logic [GW-1:0]   grant_idx;
  int              cand;
  logic [OW-1:0]   sel_data;
  lii_id_t         sel_dst;

  logic            unused_src;
  assign unused_src = ^lii_in_p0_src;

  generate
    if (PW > IW) begin : g_unused_hi
      logic unused_in_hi;
      assign unused_in_hi = ^lii_in_p0_tdata[PW-1:IW];
    end
  endgenerate

  // Inbound demux: out-of-range dst is always accepted and counted as dropped
  assign in_idx    = stream_index(lii_in_p0_dst, IN_BASE);
  assign in_idx_ok = (int'(in_idx) < NIN);

  always_comb begin
    in_sel_full = 1'b0;
    for (int i = 0; i < NIN; i++) begin
      if (in_idx == lii_id_t'(i)) in_sel_full = in_full[i];
    end
  end

  assign lii_in_p0_tready = arstn & (~in_idx_ok | ~in_sel_full);
  assign in_hs            = lii_in_p0_tvalid & lii_in_p0_tready;

  generate
    for (genvar i = 0; i < NIN; i++) begin : g_in
      assign in_push[i]               = in_hs & in_idx_ok & (in_idx == lii_id_t'(i));
      assign in_pop[i]                = ~in_empty[i] & k_in_tready[i];
      assign k_in_tvalid[i]           = ~in_empty[i];
      assign k_in_tdata[i*IW +: IW]   = in_dout[i];

      lii_sync_fifo #(.W(IW), .DEPTH(DEPTH)) u_in_fifo (
        .clk_i   (aclk),
        .rst_n_i (arstn),
        .push_i  (in_push[i]),
        .din_i   (lii_in_p0_tdata[IW-1:0]),
        .pop_i   (in_pop[i]),
        .dout_o  (in_dout[i]),
        .full_o  (in_full[i]),
        .empty_o (in_empty[i]),
        .count_o (unused_in_count[i])
      );
    end

    for (genvar j = 0; j < NOUT; j++) begin : g_out
      assign k_out_tready[j] = arstn & ~out_full[j];
      assign out_push[j]     = k_out_tvalid[j] & k_out_tready[j];
      assign out_pop[j]      = load & (grant_idx == GW'(j));

      lii_sync_fifo #(.W(OW), .DEPTH(DEPTH)) u_out_fifo (
        .clk_i   (aclk),
        .rst_n_i (arstn),
        .push_i  (out_push[j]),
        .din_i   (k_out_tdata[j*OW +: OW]),
        .pop_i   (out_pop[j]),
        .dout_o  (out_dout[j]),
        .full_o  (out_full[j]),
        .empty_o (out_empty[j]),
        .count_o (unused_out_count[j])
      );
    end
  endgenerate

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_hs && !in_idx_ok && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Round-robin: first non-empty FIFO after last_grant, searched in ascending cyclic order
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NOUT; k++) begin
      cand = (int'(last_grant_q) + k) % NOUT;
      for (int m = 0; m < NOUT; m++) begin
        if (m == cand && !grant_found && !out_empty[m]) begin
          grant_found = 1'b1;
          grant_idx   = GW'(m);
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_dst  = '0;
    for (int m = 0; m < NOUT; m++) begin
      if (grant_idx == GW'(m)) begin
        sel_data = out_dout[m];
        sel_dst  = out_dst[m*8 +: 8];
      end
    end
  end

  // Loading alongside a downstream handshake keeps the bus bubble-free
  assign load = (~ovalid_q | lii_out_p0_tready) & grant_found;

  always_comb begin
    ovalid_d     = ovalid_q;
    odata_d      = odata_q;
    osrc_d       = osrc_q;
    odst_d       = odst_q;
    last_grant_d = last_grant_q;
    if (load) begin
      ovalid_d     = 1'b1;
      odata_d      = sel_data;
      osrc_d       = OUT_BASE + lii_id_t'(grant_idx);
      odst_d       = sel_dst;
      last_grant_d = grant_idx;
    end else if (lii_out_p0_tready) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      drop_cnt_q   <= '0;
      ovalid_q     <= 1'b0;
      odata_q      <= '0;
      osrc_q       <= '0;
      odst_q       <= '0;
      last_grant_q <= GW'(NOUT - 1);
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      ovalid_q     <= ovalid_d;
      odata_q      <= odata_d;
      osrc_q       <= osrc_d;
      odst_q       <= odst_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    lii_out_p0_tdata           = '0;
    lii_out_p0_tdata[OW-1:0]   = odata_q;
  end

  assign lii_out_p0_tvalid = ovalid_q;
  assign lii_out_p0_src    = osrc_q;
  assign lii_out_p0_dst    = odst_q;
  assign ce                = ~|out_full;
  assign drop_cnt          = drop_cnt_q;

endmodule
